// File: rtl/cmd_rom_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : cmd_rom_sequencer
//  Purpose  : Walks the 36-bit load-command ROM from address 0 and presents
//             one enabled command at a time to the downstream memory
//             controller. Disabled entries are skipped, an all-zero word or
//             the last ROM address ends the run, and a per-command watchdog
//             flags a controller stall.
//
//  Ports    : clock        - rising-edge clock
//             reset        - synchronous, active-high reset
//             start        - begin a run (accepted in IDLE/EOP/ERR only)
//             rom_en       - ROM read strobe (high in FETCH only)
//             rom_addr     - ROM read address
//             rom_data     - ROM word, valid the cycle after rom_en
//             cmd          - current command word
//             cmd_valid    - cmd is live for the controller (ISSUE)
//             cmd_done     - controller completion pulse
//             busy         - high in FETCH, DECODE, ISSUE
//             eop          - sticky end-of-program flag
//             timeout_err  - sticky watchdog-expired flag
//             cmd_count    - commands completed in the current run
//
//  Revision : 1.0 - initial release
// ============================================================================
module cmd_rom_sequencer #(
    parameter int ROM_AW  = 8,
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              rom_en,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [35:0]       rom_data,
    output logic [35:0]       cmd,
    output logic              cmd_valid,
    input  logic              cmd_done,
    output logic              busy,
    output logic              eop,
    output logic              timeout_err,
    output logic [ROM_AW:0]   cmd_count
);

    localparam logic [ROM_AW-1:0] c_LAST_ADDR = {ROM_AW{1'b1}};
    // Watchdog value seen on the final permitted ISSUE cycle; the first
    // ISSUE cycle sees 0, so exactly TIMEOUT cycles elapse before expiry.
    localparam logic [TO_W-1:0]   c_WD_LAST   = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_ISSUE  = 3'd3,
        S_EOP    = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ROM_AW-1:0] r_rom_addr;
    logic [35:0]       r_cmd;
    logic              r_eop;
    logic              r_timeout_err;
    logic [ROM_AW:0]   r_cmd_count;
    logic [TO_W-1:0]   r_watchdog;

    // Datapath control strobes produced by the next-state logic
    logic              w_clr_run;
    logic              w_adv_addr;
    logic              w_load_cmd;
    logic              w_wd_inc;
    logic              w_inc_count;
    logic              w_set_eop;
    logic              w_set_err;
    logic              w_at_last;

    assign w_at_last = (r_rom_addr == c_LAST_ADDR);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_clr_run   = 1'b0;
        w_adv_addr  = 1'b0;
        w_load_cmd  = 1'b0;
        w_wd_inc    = 1'b0;
        w_inc_count = 1'b0;
        w_set_eop   = 1'b0;
        w_set_err   = 1'b0;

        case (r_state)
            S_IDLE, S_EOP, S_ERR: begin
                if (start) begin
                    w_clr_run   = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end

            S_FETCH: begin
                w_state_nxt = S_DECODE;
            end

            S_DECODE: begin
                if (rom_data == 36'h0) begin
                    w_set_eop   = 1'b1;
                    w_state_nxt = S_EOP;
                end else if (!rom_data[34]) begin
                    // Disabled entry: skip it, but never step past the
                    // last address.
                    if (w_at_last) begin
                        w_set_eop   = 1'b1;
                        w_state_nxt = S_EOP;
                    end else begin
                        w_adv_addr  = 1'b1;
                        w_state_nxt = S_FETCH;
                    end
                end else begin
                    w_load_cmd  = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end

            S_ISSUE: begin
                // Completion takes priority over a simultaneous expiry.
                if (cmd_done) begin
                    w_inc_count = 1'b1;
                    if (w_at_last) begin
                        w_set_eop   = 1'b1;
                        w_state_nxt = S_EOP;
                    end else begin
                        w_adv_addr  = 1'b1;
                        w_state_nxt = S_FETCH;
                    end
                end else if (r_watchdog == c_WD_LAST) begin
                    w_set_err   = 1'b1;
                    w_state_nxt = S_ERR;
                end else begin
                    w_wd_inc    = 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rom_addr    <= '0;
            r_cmd         <= '0;
            r_eop         <= 1'b0;
            r_timeout_err <= 1'b0;
            r_cmd_count   <= '0;
            r_watchdog    <= '0;
        end else begin
            if (w_clr_run) begin
                r_rom_addr    <= '0;
                r_cmd_count   <= '0;
                r_eop         <= 1'b0;
                r_timeout_err <= 1'b0;
            end
            if (w_adv_addr) begin
                r_rom_addr <= r_rom_addr + 1'b1;
            end
            if (w_load_cmd) begin
                r_cmd      <= rom_data;
                r_watchdog <= '0;
            end else if (w_wd_inc) begin
                r_watchdog <= r_watchdog + 1'b1;
            end
            if (w_inc_count) begin
                r_cmd_count <= r_cmd_count + 1'b1;
            end
            if (w_set_eop) begin
                r_eop <= 1'b1;
            end
            if (w_set_err) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all decoded from registered state)
    // ------------------------------------------------------------------
    assign rom_en      = (r_state == S_FETCH);
    assign cmd_valid   = (r_state == S_ISSUE);
    assign busy        = (r_state == S_FETCH) || (r_state == S_DECODE) ||
                         (r_state == S_ISSUE);
    assign rom_addr    = r_rom_addr;
    assign cmd         = r_cmd;
    assign eop         = r_eop;
    assign timeout_err = r_timeout_err;
    assign cmd_count   = r_cmd_count;

endmodule
`default_nettype wire

// File: tb/tb_cmd_rom_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cmd_rom_sequencer
//  Purpose  : Self-checking bench for cmd_rom_sequencer. Stimulus loads a
//             small ROM image and pushes the expected command windows into a
//             scoreboard queue; a monitor pops and compares each window the
//             DUT presents on cmd/cmd_valid.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cmd_rom_sequencer;

    localparam int ROM_AW  = 2;
    localparam int TIMEOUT = 16;
    localparam int TO_W    = 8;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              rom_en;
    logic [ROM_AW-1:0] rom_addr;
    logic [35:0]       rom_data = '0;
    logic [35:0]       cmd;
    logic              cmd_valid;
    logic              cmd_done = 1'b0;
    logic              busy;
    logic              eop;
    logic              timeout_err;
    logic [ROM_AW:0]   cmd_count;

    cmd_rom_sequencer #(
        .ROM_AW  (ROM_AW),
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .rom_en      (rom_en),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .cmd         (cmd),
        .cmd_valid   (cmd_valid),
        .cmd_done    (cmd_done),
        .busy        (busy),
        .eop         (eop),
        .timeout_err (timeout_err),
        .cmd_count   (cmd_count)
    );

    always #5 clock = ~clock;

    // Synchronous ROM model
    logic [35:0] rom [0:3];
    always @(posedge clock) begin
        if (rom_en) rom_data <= rom[rom_addr];
    end

    int fetch_cnt = 0;
    always @(posedge clock) begin
        if (rom_en) fetch_cnt = fetch_cnt + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Controller model: cmd_done on ISSUE cycle number done_at (0 = never),
    // plus an unconditional force from the stimulus.
    int   done_at    = 1;
    logic force_done = 1'b0;
    int   resp_cyc   = 0;
    always @(negedge clock) begin
        if (cmd_valid) resp_cyc = resp_cyc + 1;
        else           resp_cyc = 0;
        cmd_done = force_done || (cmd_valid && done_at != 0 && resp_cyc == done_at);
    end

    // Scoreboard: expected command word and window length (0 = unchecked)
    typedef struct {
        logic [35:0] word;
        int          len;
    } exp_t;
    exp_t exp_q[$];

    logic        prev_valid = 1'b0;
    int          win_len    = 0;
    int          cur_len    = 0;
    logic [35:0] hold_cmd   = '0;
    logic        stable     = 1'b1;
    always @(negedge clock) begin
        if (cmd_valid && !prev_valid) begin
            win_len  = 1;
            hold_cmd = cmd;
            stable   = 1'b1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_cmd: got %0h expected none", cmd);
                cur_len = 0;
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                cur_len = e.len;
                check("cmd_word", {28'd0, cmd}, {28'd0, e.word});
            end
        end else if (cmd_valid) begin
            win_len = win_len + 1;
            if (cmd !== hold_cmd) stable = 1'b0;
        end else if (prev_valid) begin
            check("cmd_stable", {63'd0, stable}, 64'd1);
            if (cur_len != 0)
                check("valid_len", 64'(win_len), 64'(cur_len));
        end
        prev_valid = cmd_valid;
    end

    task automatic push(input logic [35:0] w, input int len);
        exp_t e;
        e.word = w;
        e.len  = len;
        exp_q.push_back(e);
    endtask

    // Returns in the cycle after start was sampled (FETCH cycle)
    task automatic pulse_start();
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
    endtask

    task automatic wait_run_end(input string name);
        int n = 0;
        while (busy && n < 400) begin
            @(negedge clock);
            n++;
        end
        check(name, {63'd0, busy}, 64'd0);
    endtask

    // Cycles from the FETCH cycle to the first cmd_valid, counting FETCH as 1
    task automatic latency_to_valid(output int lat);
        lat = 1;
        while (!cmd_valid && lat < 50) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic wait_valid_edge(input logic level);
        int n = 0;
        while (cmd_valid !== level && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("wait_valid", {63'd0, cmd_valid}, {63'd0, level});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rom_en"},   {63'd0, rom_en},      64'd0);
        check({tag, "_rom_addr"}, 64'(rom_addr),        64'd0);
        check({tag, "_cmd"},      {28'd0, cmd},         64'd0);
        check({tag, "_valid"},    {63'd0, cmd_valid},   64'd0);
        check({tag, "_busy"},     {63'd0, busy},        64'd0);
        check({tag, "_eop"},      {63'd0, eop},         64'd0);
        check({tag, "_to_err"},   {63'd0, timeout_err}, 64'd0);
        check({tag, "_count"},    64'(cmd_count),       64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int lat;
        int fbase;

        // ---------------- Reset state ----------------
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_reset_outputs("rst");

        // ---------------- Two enabled commands, done 3 cycles after rise
        rom[0] = 36'h4_1000_0040;
        rom[1] = 36'h4_2000_0020;
        rom[2] = 36'h0;
        rom[3] = 36'h4_FFFF_FFFF;
        done_at = 4;
        push(rom[0], 4);
        push(rom[1], 4);
        pulse_start();
        check("t1_fetch_en",   {63'd0, rom_en}, 64'd1);
        check("t1_fetch_addr", 64'(rom_addr),   64'd0);
        check("t1_fetch_busy", {63'd0, busy},   64'd1);
        latency_to_valid(lat);
        check("t1_latency", 64'(lat), 64'd3);
        wait_run_end("t1_end");
        check("t1_count", 64'(cmd_count), 64'd2);
        check("t1_eop",   {63'd0, eop},   64'd1);
        check("t1_addr",  64'(rom_addr),  64'd2);
        check("t1_cmd_hold", {28'd0, cmd}, {28'd0, 36'h4_2000_0020});
        check("t1_q_empty", 64'(exp_q.size()), 64'd0);

        // ---------------- Disabled word skipped
        rom[0] = 36'h2_0000_0010;
        rom[1] = 36'h4_3000_0008;
        rom[2] = 36'h0;
        done_at = 1;
        push(rom[1], 1);
        pulse_start();
        check("t2_eop_clr", {63'd0, eop}, 64'd0);
        latency_to_valid(lat);
        check("t2_latency", 64'(lat), 64'd5);
        wait_run_end("t2_end");
        check("t2_count", 64'(cmd_count), 64'd1);
        check("t2_eop",   {63'd0, eop},   64'd1);
        check("t2_q_empty", 64'(exp_q.size()), 64'd0);

        // ---------------- Watchdog timeout, then restart
        rom[0] = 36'h4_4000_0001;
        rom[1] = 36'h0;
        done_at = 0;
        push(rom[0], TIMEOUT);
        pulse_start();
        wait_run_end("t3_end");
        check("t3_to_err", {63'd0, timeout_err}, 64'd1);
        check("t3_eop",    {63'd0, eop},         64'd0);
        check("t3_count",  64'(cmd_count),       64'd0);
        done_at = 1;
        push(rom[0], 1);
        pulse_start();
        check("t3_err_clr",  {63'd0, timeout_err}, 64'd0);
        check("t3_refetch",  {63'd0, rom_en},      64'd1);
        check("t3_addr0",    64'(rom_addr),        64'd0);
        wait_run_end("t3_end2");
        check("t3_count2", 64'(cmd_count), 64'd1);
        check("t3_eop2",   {63'd0, eop},   64'd1);

        // ---------------- Full ROM, last address ends the run
        rom[0] = 36'hF_0001_0002;
        rom[1] = 36'h5_0002_0003;
        rom[2] = 36'h6_0003_0004;
        rom[3] = 36'h7_0004_0005;
        done_at = 1;
        for (int i = 0; i < 4; i++) push(rom[i], 1);
        fbase = fetch_cnt;
        pulse_start();
        wait_run_end("t4_end");
        repeat (3) @(negedge clock);
        check("t4_count",   64'(cmd_count),         64'd4);
        check("t4_eop",     {63'd0, eop},           64'd1);
        check("t4_addr",    64'(rom_addr),          64'd3);
        check("t4_fetches", 64'(fetch_cnt - fbase), 64'd4);

        // ---------------- cmd_done on the watchdog's final cycle
        rom[0] = 36'h4_5000_0011;
        rom[1] = 36'h4_6000_0022;
        rom[2] = 36'h0;
        done_at = TIMEOUT;
        push(rom[0], TIMEOUT);
        push(rom[1], TIMEOUT);
        pulse_start();
        wait_run_end("t5_end");
        check("t5_to_err", {63'd0, timeout_err}, 64'd0);
        check("t5_count",  64'(cmd_count),       64'd2);
        check("t5_eop",    {63'd0, eop},         64'd1);

        // ---------------- Reset during ISSUE with cmd_done high
        rom[0] = 36'h4_7000_0001;
        rom[1] = 36'h4_8000_0002;
        rom[2] = 36'h0;
        done_at = 1;
        push(rom[0], 1);
        push(rom[1], 0);
        pulse_start();
        wait_valid_edge(1'b1);
        wait_valid_edge(1'b0);
        done_at = 0;
        wait_valid_edge(1'b1);
        @(negedge clock);
        check("t6_count_pre", 64'(cmd_count), 64'd1);
        reset      = 1'b1;
        force_done = 1'b1;
        @(negedge clock);
        reset      = 1'b0;
        force_done = 1'b0;
        check_reset_outputs("t6");
        repeat (3) @(negedge clock);
        check("t6_idle_busy", {63'd0, busy}, 64'd0);

        // ---------------- cmd_done in IDLE and start in ISSUE ignored
        force_done = 1'b1;
        @(negedge clock);
        force_done = 1'b0;
        repeat (2) @(negedge clock);
        check("t7_idle_busy",  {63'd0, busy},   64'd0);
        check("t7_idle_count", 64'(cmd_count),  64'd0);
        rom[0] = 36'h4_9000_0003;
        rom[1] = 36'h4_A000_0004;
        rom[2] = 36'h0;
        done_at = 3;
        push(rom[0], 3);
        push(rom[1], 3);
        pulse_start();
        wait_valid_edge(1'b1);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_run_end("t7_end");
        check("t7_count", 64'(cmd_count), 64'd2);
        check("t7_eop",   {63'd0, eop},   64'd1);
        check("t7_addr",  64'(rom_addr),  64'd2);
        check("t7_q_empty", 64'(exp_q.size()), 64'd0);

        repeat (2) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cmd_rom_sequencer.md
# cmd_rom_sequencer

Steps through the 36-bit load-command ROM and presents one command word at a time to the memory controller. Sits directly upstream of the controller. Fetches sequentially from address 0, skips disabled entries, and holds each enabled command until the controller reports completion. Ends on an all-zero word or after the last ROM address, and flags a watchdog timeout if the controller stalls.

## Interface
- ROM_AW, 8, command-ROM address width (depth 2^ROM_AW words)
- TIMEOUT, 1024, maximum ISSUE cycles per command before error (≥2)
- TO_W, 16, watchdog counter width (2^TO_W > TIMEOUT)

- clock  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; overrides every other input
- start  in  1  begin a run from address 0; sampled only in IDLE, EOP, ERR
- rom_en  out  1  ROM read strobe
- rom_addr  out  ROM_AW  ROM read address
- rom_data  in  36  ROM word, valid the cycle after rom_en=1 (synchronous ROM)
- cmd  out  36  current command; field map [35] rst, [34] en, [33] select, [32] read, [31:16] start address, [15:0] size
- cmd_valid  out  1  cmd is live for the controller
- cmd_done  in  1  controller completion pulse; sampled only while cmd_valid=1
- busy  out  1  high in FETCH, DECODE, ISSUE
- eop  out  1  end of program reached; sticky until start or reset
- timeout_err  out  1  watchdog expired; sticky until start or reset
- cmd_count  out  ROM_AW+1  number of commands completed this run

## Operation
- States: IDLE, FETCH, DECODE, ISSUE, EOP, ERR.
- IDLE/EOP/ERR + start=1: rom_addr←0, cmd_count←0, eop←0, timeout_err←0, go to FETCH. start is ignored in every other state.
- FETCH: rom_en=1 for exactly this cycle, then go to DECODE. rom_en=0 in all other states.
- DECODE: rom_data is examined.
  - rom_data==36'h0: go to EOP, eop←1.
  - rom_data[34]==0 (non-zero, disabled): skip the word. If rom_addr is the last address, go to EOP. Otherwise rom_addr+1 and go to FETCH.
  - else: cmd←rom_data, watchdog←0, go to ISSUE.
- ISSUE: cmd_valid=1 and cmd is held stable. The watchdog increments each cycle.
  - cmd_done=1: cmd_count+1. If rom_addr is the last address (2^ROM_AW−1), go to EOP with eop←1. Otherwise rom_addr+1 and go to FETCH.
  - watchdog reaches TIMEOUT−1 with cmd_done=0: go to ERR, timeout_err←1.
  - Both events in the same cycle: cmd_done wins, no error.
- rom_addr does not wrap. The last address ends the run.
- cmd retains its last value after ISSUE exits. It is cleared only by reset.
- cmd_count increments modulo 2^(ROM_AW+1). It cannot overflow in one run.
- cmd_done outside ISSUE has no effect.

## Timing
- Reset values: state IDLE, rom_en 0, rom_addr 0, cmd 0, cmd_valid 0, busy 0, eop 0, timeout_err 0, cmd_count 0, watchdog 0.
- Reset asserted mid-run, in any state: all of the above values appear after the next rising edge. A pending cmd_done is discarded.
- start sampled at edge N: FETCH at N+1 (rom_en=1, rom_addr=0), DECODE at N+2, cmd_valid=1 from N+3.
- Per enabled command: 2 cycles of overhead (FETCH + DECODE) plus the ISSUE cycles. cmd_valid drops the cycle after cmd_done is sampled.
- The minimum ISSUE length is 1 cycle (cmd_done high on the first cycle of cmd_valid).
- Each skipped word costs 2 cycles.
- Timeout: with no cmd_done, cmd_valid stays high for exactly TIMEOUT cycles. timeout_err rises the cycle after the last of them, together with cmd_valid falling.
- eop and timeout_err rise in the same cycle busy falls.

## Test plan
- ROM {addr0: en=1 size 0x0040, addr1: en=1 size 0x0020, addr2: 0}, start pulse, cmd_done 3 cycles after each cmd_valid rise -> two ISSUE windows with cmd equal to the ROM words, cmd_count=2, eop=1, busy=0, rom_addr=2.
- ROM {addr0: 36'h2_0000_0010 (en=0, non-zero), addr1: en=1, addr2: 0} -> addr0 is never presented; the first cmd_valid shows the addr1 word at start+5; cmd_count=1.
- TIMEOUT=16, one enabled command, cmd_done held low -> cmd_valid high for exactly 16 cycles, then timeout_err=1, busy=0, cmd_count=0; a following start clears timeout_err and refetches addr0.
- ROM_AW=2, all four words enabled and non-zero, immediate cmd_done -> 4 commands issued, eop=1 after the 4th, rom_addr=3, no access beyond address 3.
- cmd_done asserted on the same cycle the watchdog hits TIMEOUT−1 -> command completes, timeout_err stays 0, next FETCH proceeds.
- Reset asserted during ISSUE with cmd_done=1 -> all outputs at reset values the next cycle, cmd_count=0. Separately, start pulsed during ISSUE and cmd_done pulsed in IDLE are both ignored.
